// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default operand width.
package serial_adder_pkg;

  localparam int SA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders; purely combinational, no flow control.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first through one full_adder; done pulses WIDTH+1 cycles after start, start ignored while busy.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        // Last bit: publish the shift register including the bit computed this cycle.
        if (cnt_q == CNT_LAST) begin
          sum_d   = res_sr_d;
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8); checks ovf too when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] last_sum = 8'h00;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One addition with a single-cycle start; checks RUN length, sum hold, done pulse and result.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                        input logic [7:0] es, input logic ec, input logic eo);
    a = ia; b = ib; cin = icin; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("busy_run%0d", i), {31'b0, busy}, 32'd1);
      chk($sformatf("done_run%0d", i), {31'b0, done}, 32'd0);
      if (i == 3) chk("sum_hold", {24'b0, sum}, {24'b0, last_sum});
      tick();
    end
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    chk("sum", {24'b0, sum}, {24'b0, es});
    chk("cout", {31'b0, cout}, {31'b0, ec});
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", {31'b0, ovf}, {31'b0, eo});
`else
    if (eo) begin end
`endif
    tick();
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    last_sum = es;
  endtask

  int pulses;
  int first_at;
  int second_at;

  initial begin
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", {24'b0, sum}, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Held start: re-triggers only after IDLE is re-entered.
    pulses = 0; first_at = -1; second_at = -1;
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 5) chk("held_sum_hold", {24'b0, sum}, 32'hFF);
      if (done) begin
        pulses++;
        if (pulses == 1) first_at = k; else second_at = k;
        chk($sformatf("held_sum_p%0d", pulses), {24'b0, sum}, 32'h07);
      end
    end
    start = 1'b0;
    chk("held_pulses", pulses, 32'd2);
    chk("held_first_at", first_at, 32'd9);
    chk("held_spacing", second_at - first_at, 32'd10);
    tick();
    chk("held_idle", {31'b0, busy}, 32'd0);
    last_sum = 8'h07;

    // Reset during the 4th RUN cycle abandons the operation.
    a = 8'h11; b = 8'h22; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #0.5;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_sum", {24'b0, sum}, 32'd0);
    chk("midrst_cout", {31'b0, cout}, 32'd0);
    #0.5 rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) pulses++;
    end
    chk("midrst_no_done", pulses, 32'd0);
    chk("midrst_idle", {31'b0, busy}, 32'd0);
    last_sum = 8'h00;

    run_op(8'h20, 8'h22, 1'b0, 8'h42, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
